asymm_concat_fwft_fifo: RTL and testbench

Single-clock, width-asymmetric, first-word-fall-through FIFO for the concat direction (`async_fifo_asymm_concat_fwft` behaviour). It accepts narrow write words and packs 2^WIDTH_RATIO_LOG2 of them, first-written in the least-significant lane, into one wide read word. The block sits between a byte-oriented producer and a wide-datapath consumer in the same clock domain.

---
 rtl/asymm_concat_fwft_fifo_if.sv | 25 ++
 rtl/asymm_concat_fwft_fifo.sv | 107 ++++++++++
 tb/tb_asymm_concat_fwft_fifo.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/asymm_concat_fwft_fifo_if.sv
// Bus bundle for the width-asymmetric concat FIFO: narrow write side, wide FWFT read side.
// Handshake: a write transfers on a rising edge where wr_en=1 and full=0; a read pops on a
// rising edge where rd_en=1 and empty=0; rd_data is valid exactly while empty=0.
interface asymm_concat_fwft_fifo_if #(
  parameter int WR_W = 8,
  parameter int RD_W = 32
);
  logic            wr_en;
  logic [WR_W-1:0] wr_data;
  logic            full;
  logic            rd_en;
  logic [RD_W-1:0] rd_data;
  logic            empty;
  logic            has_data;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, rd_data, empty, has_data
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, rd_data, empty, has_data
  );
endinterface

// File: rtl/asymm_concat_fwft_fifo.sv
// Single-clock FIFO packing R narrow writes (first write in lane 0) into one wide word,
// with a first-word-fall-through output register in front of the wide memory.
module asymm_concat_fwft_fifo #(
  parameter int WR_WIDTH_BYTES   = 1,
  parameter int WR_ADDR_WIDTH    = 4,
  parameter int WIDTH_RATIO_LOG2 = 2,
  parameter int RESERVE          = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  asymm_concat_fwft_fifo_if.slave bus
);
  localparam int W       = 8 * WR_WIDTH_BYTES;
  localparam int R       = 1 << WIDTH_RATIO_LOG2;
  localparam int LW      = WIDTH_RATIO_LOG2;
  localparam int AW      = WR_ADDR_WIDTH - WIDTH_RATIO_LOG2;
  localparam int PW      = AW + 1;
  localparam int DEPTH_W = 1 << AW;
  localparam int LIMIT   = DEPTH_W + 1 - RESERVE;

  logic [R-2:0][W-1:0] lane_q, lane_d;
  logic [LW-1:0]       lane_cnt_q, lane_cnt_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [R*W-1:0]      out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [R*W-1:0]      mem_q [DEPTH_W];

  logic [R*W-1:0] wide_word;
  logic [PW-1:0]  mem_count;
  logic [PW:0]    wide_count;
  logic           mem_empty;
  logic           full;
  logic           wr_accept;
  logic           pop;
  logic           complete;
  logic           load;

  always_comb begin
    mem_count  = wr_ptr_q - rd_ptr_q;
    mem_empty  = (mem_count == '0);
    // Occupancy counts the output register too, so a completing write can never overflow.
    wide_count = {1'b0, mem_count} + {{PW{1'b0}}, out_valid_q};
    full       = (wide_count >= (PW+1)'(LIMIT));
    wr_accept  = bus.wr_en && !full;
    pop        = bus.rd_en && out_valid_q;
    complete   = wr_accept && (lane_cnt_q == LW'(R - 1));
    load       = (!out_valid_q || pop) && !mem_empty;

    wide_word = '0;
    for (int k = 0; k < R - 1; k++) begin
      wide_word[k*W +: W] = lane_q[k];
    end
    wide_word[(R-1)*W +: W] = bus.wr_data;

    lane_d = lane_q;
    for (int k = 0; k < R - 1; k++) begin
      if (wr_accept && (lane_cnt_q == LW'(k))) begin
        lane_d[k] = bus.wr_data;
      end
    end
    lane_cnt_d = wr_accept ? lane_cnt_q + LW'(1) : lane_cnt_q;

    wr_ptr_d = complete ? wr_ptr_q + PW'(1) : wr_ptr_q;

    out_d       = out_q;
    out_valid_d = out_valid_q;
    rd_ptr_d    = rd_ptr_q;
    if (load) begin
      out_d       = mem_q[rd_ptr_q[AW-1:0]];
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + PW'(1);
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q      <= '0;
      lane_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      lane_cnt_q  <= lane_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage array is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (complete) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wide_word;
    end
  end

  assign bus.full     = full;
  assign bus.empty    = !out_valid_q;
  assign bus.rd_data  = out_valid_q ? out_q : '0;
  assign bus.has_data = out_valid_q || !mem_empty || (lane_cnt_q != '0);
endmodule

// File: tb/tb_asymm_concat_fwft_fifo.sv
// Randomised bench for the concat FWFT FIFO: three configurations (R=4, R=2, R=4 with one
// reserved slot) checked against a queue-based model of completed words and staged bytes.
module tb_asymm_concat_fwft_fifo;
  logic       clk;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_en_a    [3];
  logic       rd_en_a    [3];
  logic       full_a     [3];
  logic       empty_a    [3];
  logic       has_data_a [3];
  logic [31:0] rd_data_a [3];

  int vectors;
  int miscompares;
  int cyc;

  logic [31:0] wq_data  [$];
  int          wq_avail [$];
  logic [7:0]  stage_q  [$];

  asymm_concat_fwft_fifo_if #(.WR_W(8), .RD_W(32)) if0 ();
  asymm_concat_fwft_fifo_if #(.WR_W(8), .RD_W(16)) if1 ();
  asymm_concat_fwft_fifo_if #(.WR_W(8), .RD_W(32)) if2 ();

  asymm_concat_fwft_fifo #(.WR_WIDTH_BYTES(1), .WR_ADDR_WIDTH(4), .WIDTH_RATIO_LOG2(2), .RESERVE(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  asymm_concat_fwft_fifo #(.WR_WIDTH_BYTES(1), .WR_ADDR_WIDTH(4), .WIDTH_RATIO_LOG2(1), .RESERVE(0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  asymm_concat_fwft_fifo #(.WR_WIDTH_BYTES(1), .WR_ADDR_WIDTH(4), .WIDTH_RATIO_LOG2(2), .RESERVE(1))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.wr_en = wr_en_a[0];  assign if0.wr_data = wr_data;  assign if0.rd_en = rd_en_a[0];
  assign if1.wr_en = wr_en_a[1];  assign if1.wr_data = wr_data;  assign if1.rd_en = rd_en_a[1];
  assign if2.wr_en = wr_en_a[2];  assign if2.wr_data = wr_data;  assign if2.rd_en = rd_en_a[2];

  assign full_a[0] = if0.full;  assign empty_a[0] = if0.empty;  assign has_data_a[0] = if0.has_data;
  assign full_a[1] = if1.full;  assign empty_a[1] = if1.empty;  assign has_data_a[1] = if1.has_data;
  assign full_a[2] = if2.full;  assign empty_a[2] = if2.empty;  assign has_data_a[2] = if2.has_data;
  assign rd_data_a[0] = if0.rd_data;
  assign rd_data_a[1] = {16'h0000, if1.rd_data};
  assign rd_data_a[2] = if2.rd_data;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Reference model: lanes per wide word and usable wide capacity for each configuration.
  function automatic int rr(input int d);
    return (d == 1) ? 2 : 4;
  endfunction

  function automatic int lim(input int d);
    int depth_w;
    depth_w = 16 / rr(d);
    return depth_w + 1 - ((d == 2) ? 1 : 0);
  endfunction

  // A completed word is presentable from one edge after completion, once it reaches the head.
  function automatic bit m_visible();
    return (wq_data.size() > 0) && (cyc >= wq_avail[0]);
  endfunction

  function automatic logic [34:0] m_vec(input int d);
    bit vis;
    vis = m_visible();
    return {!vis, (wq_data.size() >= lim(d)), ((wq_data.size() > 0) || (stage_q.size() > 0)),
            vis ? wq_data[0] : 32'h0};
  endfunction

  function automatic logic [34:0] o_vec(input int d);
    return {empty_a[d], full_a[d], has_data_a[d], rd_data_a[d]};
  endfunction

  function automatic void m_clear();
    wq_data.delete();
    wq_avail.delete();
    stage_q.delete();
  endfunction

  // Driver tasks
  task automatic step(input int d, input bit we, input logic [7:0] wd, input bit re);
    bit acc;
    bit pop;
    logic [31:0] w;
    acc = we && (wq_data.size() < lim(d));
    pop = re && m_visible();
    wr_en_a[d] = we;
    wr_data    = wd;
    rd_en_a[d] = re;
    @(posedge clk);
    #1;
    wr_en_a[d] = 1'b0;
    rd_en_a[d] = 1'b0;
    cyc++;
    if (pop) begin
      void'(wq_data.pop_front());
      void'(wq_avail.pop_front());
    end
    if (acc) begin
      stage_q.push_back(wd);
      if (stage_q.size() == rr(d)) begin
        w = '0;
        foreach (stage_q[i]) w[8*i +: 8] = stage_q[i];
        wq_data.push_back(w);
        wq_avail.push_back(cyc + 1);
        stage_q.delete();
      end
    end
  endtask

  task automatic apply_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en_a[i] = 1'b0;
      rd_en_a[i] = 1'b0;
    end
    wr_data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en_a[i] = 1'b0;
      rd_en_a[i] = 1'b0;
    end
    wr_data = '0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (o_vec(d) !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
        miscompares++;
        $display("FAIL reset_held dut%0d: got %h expected %h", d, o_vec(d), {1'b1, 1'b0, 1'b0, 32'h0});
      end
    end
    apply_reset();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (o_vec(d) !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
        miscompares++;
        $display("FAIL reset_released dut%0d: got %h expected %h", d, o_vec(d), {1'b1, 1'b0, 1'b0, 32'h0});
      end
    end
  endtask

  task automatic test_r2_sequence();
    int b;
    int popped;
    apply_reset();
    b = 0;
    for (int i = 0; i < 60 && b < 10; i++) begin
      if ($urandom_range(0, 2) == 0) step(1, 1'b0, 8'h00, 1'b0);
      else begin
        step(1, 1'b1, 8'(b), 1'b0);
        b++;
      end
      vectors++;
      if (o_vec(1) !== m_vec(1)) begin
        miscompares++;
        $display("FAIL r2_write cyc=%0d: got %h expected %h", cyc, o_vec(1), m_vec(1));
      end
    end
    popped = 0;
    for (int i = 0; i < 40 && popped < 5; i++) begin
      if (!empty_a[1]) begin
        vectors++;
        if (rd_data_a[1] !== {16'h0, 8'(2*popped + 1), 8'(2*popped)}) begin
          miscompares++;
          $display("FAIL r2_pop_value #%0d: got %h expected %h", popped, rd_data_a[1],
                   {16'h0, 8'(2*popped + 1), 8'(2*popped)});
        end
        step(1, 1'b0, 8'h00, 1'b1);
        popped++;
      end else step(1, 1'b0, 8'h00, 1'b0);
      vectors++;
      if (o_vec(1) !== m_vec(1)) begin
        miscompares++;
        $display("FAIL r2_pop cyc=%0d: got %h expected %h", cyc, o_vec(1), m_vec(1));
      end
    end
    vectors++;
    if (popped != 5 || empty_a[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL r2_drained: got pops=%0d empty=%b expected pops=5 empty=1", popped, empty_a[1]);
    end
  endtask

  task automatic test_r4_fill();
    int popped;
    apply_reset();
    for (int b = 0; b < 21; b++) begin
      step(0, 1'b1, 8'(b), 1'b0);
      vectors++;
      if (o_vec(0) !== m_vec(0)) begin
        miscompares++;
        $display("FAIL fill_write byte=%0d: got %h expected %h", b, o_vec(0), m_vec(0));
      end
      if (b == 19) begin
        vectors++;
        if (full_a[0] !== 1'b1) begin
          miscompares++;
          $display("FAIL fill_full_after_20: got %b expected 1", full_a[0]);
        end
      end
    end
    popped = 0;
    for (int i = 0; i < 20 && popped < 5; i++) begin
      if (!empty_a[0]) begin
        vectors++;
        if (rd_data_a[0] !== {8'(4*popped + 3), 8'(4*popped + 2), 8'(4*popped + 1), 8'(4*popped)}) begin
          miscompares++;
          $display("FAIL fill_pop_value #%0d: got %h expected %h", popped, rd_data_a[0],
                   {8'(4*popped + 3), 8'(4*popped + 2), 8'(4*popped + 1), 8'(4*popped)});
        end
        step(0, 1'b0, 8'h00, 1'b1);
        popped++;
      end else step(0, 1'b0, 8'h00, 1'b0);
      vectors++;
      if (o_vec(0) !== m_vec(0)) begin
        miscompares++;
        $display("FAIL fill_pop cyc=%0d: got %h expected %h", cyc, o_vec(0), m_vec(0));
      end
    end
    vectors++;
    if (popped != 5 || o_vec(0) !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL fill_drained: got pops=%0d out=%h expected pops=5 out=%h", popped, o_vec(0),
               {1'b1, 1'b0, 1'b0, 32'h0});
    end
  endtask

  task automatic test_partial();
    logic [7:0] bytes [4];
    apply_reset();
    for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++) step(0, 1'b1, bytes[i], 1'b0);
    vectors++;
    if (has_data_a[0] !== 1'b1 || empty_a[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL partial_staged: got has_data=%b empty=%b expected 1 1", has_data_a[0], empty_a[0]);
    end
    step(0, 1'b0, 8'h00, 1'b1);
    vectors++;
    if (o_vec(0) !== m_vec(0)) begin
      miscompares++;
      $display("FAIL partial_rd_ignored: got %h expected %h", o_vec(0), m_vec(0));
    end
    step(0, 1'b1, bytes[3], 1'b0);
    vectors++;
    if (empty_a[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL partial_latency_edge1: got empty=%b expected 1", empty_a[0]);
    end
    step(0, 1'b0, 8'h00, 1'b0);
    vectors++;
    if (empty_a[0] !== 1'b0 || rd_data_a[0] !== {bytes[3], bytes[2], bytes[1], bytes[0]}) begin
      miscompares++;
      $display("FAIL partial_latency_edge2: got empty=%b data=%h expected 0 %h", empty_a[0],
               rd_data_a[0], {bytes[3], bytes[2], bytes[1], bytes[0]});
    end
  endtask

  task automatic test_streaming();
    int full_seen;
    apply_reset();
    full_seen = 0;
    for (int i = 0; i < 400; i++) begin
      step(0, 1'b1, 8'($urandom_range(0, 255)), !empty_a[0]);
      if (full_a[0]) full_seen++;
      vectors++;
      if (o_vec(0) !== m_vec(0)) begin
        miscompares++;
        $display("FAIL stream cyc=%0d: got %h expected %h", cyc, o_vec(0), m_vec(0));
      end
    end
    for (int i = 0; i < 20; i++) begin
      step(0, 1'b0, 8'h00, !empty_a[0]);
      vectors++;
      if (o_vec(0) !== m_vec(0)) begin
        miscompares++;
        $display("FAIL stream_drain cyc=%0d: got %h expected %h", cyc, o_vec(0), m_vec(0));
      end
    end
    vectors++;
    if (full_seen != 0 || has_data_a[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_summary: got full_cycles=%0d has_data=%b expected 0 0", full_seen, has_data_a[0]);
    end
  endtask

  task automatic test_random(input int d);
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      step(d, ($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)), ($urandom_range(0, 9) < 4));
      vectors++;
      if (o_vec(d) !== m_vec(d)) begin
        miscompares++;
        $display("FAIL random dut%0d cyc=%0d: got %h expected %h", d, cyc, o_vec(d), m_vec(d));
      end
    end
  endtask

  task automatic test_reserve();
    apply_reset();
    for (int b = 0; b < 16; b++) step(2, 1'b1, 8'(b), 1'b0);
    step(2, 1'b0, 8'h00, 1'b0);
    vectors++;
    if (full_a[2] !== 1'b1 || rd_data_a[2] !== 32'h03020100) begin
      miscompares++;
      $display("FAIL reserve_full_16: got full=%b data=%h expected 1 03020100", full_a[2], rd_data_a[2]);
    end
    step(2, 1'b1, 8'hEE, 1'b1);
    vectors++;
    if (o_vec(2) !== m_vec(2) || full_a[2] !== 1'b0 || rd_data_a[2] !== 32'h07060504) begin
      miscompares++;
      $display("FAIL reserve_pop_at_full: got %h expected %h", o_vec(2), m_vec(2));
    end
    for (int i = 0; i < 3; i++) step(2, 1'b0, 8'h00, 1'b1);
    vectors++;
    if (o_vec(2) !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reserve_write_dropped: got %h expected %h", o_vec(2), {1'b1, 1'b0, 1'b0, 32'h0});
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int b = 0; b < 6; b++) step(0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    step(0, 1'b0, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (o_vec(0) !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL midstream_async_reset: got %h expected %h", o_vec(0), {1'b1, 1'b0, 1'b0, 32'h0});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_clear();
    for (int b = 0; b < 4; b++) step(0, 1'b1, 8'hA0 + 8'(b), 1'b0);
    step(0, 1'b0, 8'h00, 1'b0);
    vectors++;
    if (rd_data_a[0] !== 32'hA3A2A1A0 || o_vec(0) !== m_vec(0)) begin
      miscompares++;
      $display("FAIL midstream_fresh_data: got %h expected %h", o_vec(0), {1'b0, 1'b0, 1'b1, 32'hA3A2A1A0});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    test_reset();
    test_r2_sequence();
    test_r4_fill();
    test_partial();
    test_streaming();
    test_random(0);
    test_random(1);
    test_random(2);
    test_reserve();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
